// File: rtl/bpf_pkg.sv
// Shared constants for the instruction-memory loader: FSM state encoding,
// instruction width and the default frame depth.
package bpf_pkg;
    localparam int INSN_W    = 16;
    localparam int DEPTH_DEF = 256;

    localparam logic [2:0] LEN_HI  = 3'd0;
    localparam logic [2:0] LEN_LO  = 3'd1;
    localparam logic [2:0] DATA_HI = 3'd2;
    localparam logic [2:0] DATA_LO = 3'd3;
    localparam logic [2:0] CSUM    = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, RAM write port and status of the instruction loader.
// Handshake: a byte transfers on a posedge where iVALID && oREADY are both 1;
// the host may hold iVALID while oREADY is 0 and nothing is consumed.
interface imem_loader_if import bpf_pkg::*; #(parameter int ADDR_W = 8) ();
    logic [7:0]        iDATA;
    logic              iVALID;
    logic              oREADY;
    logic              iRELOAD;
    logic              oWE;
    logic [ADDR_W-1:0] oWADDR;
    logic [INSN_W-1:0] oWDATA;
    logic              oRUN;
    logic              oERR;
    logic [ADDR_W:0]   oCOUNT;
    logic [2:0]        oSTATE;

    modport master (
        output iDATA, iVALID, iRELOAD,
        input  oREADY, oWE, oWADDR, oWDATA, oRUN, oERR, oCOUNT, oSTATE
    );

    modport slave (
        input  iDATA, iVALID, iRELOAD,
        output oREADY, oWE, oWADDR, oWDATA, oRUN, oERR, oCOUNT, oSTATE
    );
endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Pairs a latched high byte with the following low byte into one instruction
// word; o_valid is a registered one-cycle pulse, o_word holds between pulses.
module byte_to_word import bpf_pkg::*; (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_hi_en,
    input  logic              i_lo_en,
    input  logic [7:0]        i_byte,
    output logic [INSN_W-1:0] o_word,
    output logic              o_valid
);
    logic [7:0]        r_hi;
    logic [INSN_W-1:0] r_word;
    logic              r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi    <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= i_lo_en;
            if (i_hi_en) r_hi <= i_byte;
            if (i_lo_en) r_word <= {r_hi, i_byte};
        end
    end

    assign o_word  = r_word;
    assign o_valid = r_valid;
endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte frame into instruction RAM
// from address 0 and releases the CPU (oRUN) once the checksum matches.
module imem_loader import bpf_pkg::*; #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic    iCLK,
    input  logic    iRST,
    imem_loader_if.slave bus
);
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    logic [2:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_len;
    logic [7:0]        r_len_hi;
    logic [7:0]        r_acc;
    logic [ADDR_W-1:0] r_waddr;

    logic              w_ready;
    logic              w_accept;
    logic              w_hi_en;
    logic              w_lo_en;
    logic              w_last;
    logic [15:0]       w_len_full;
    logic [ADDR_W:0]   w_count_nxt;
    logic [INSN_W-1:0] w_word;
    logic              w_we;

    assign w_ready     = (r_state != DONE) && (r_state != ERR);
    assign w_accept    = bus.iVALID && w_ready;
    assign w_hi_en     = w_accept && (r_state == DATA_HI);
    assign w_lo_en     = w_accept && (r_state == DATA_LO);
    assign w_len_full  = {r_len_hi, bus.iDATA};
    assign w_count_nxt = r_count + {{ADDR_W{1'b0}}, 1'b1};
    // r_len never exceeds DEPTH, so the incremented count cannot wrap
    assign w_last      = (w_count_nxt == r_len);

    byte_to_word u_b2w (
        .i_clk   (iCLK),
        .i_rst_n (iRST),
        .i_hi_en (w_hi_en),
        .i_lo_en (w_lo_en),
        .i_byte  (bus.iDATA),
        .o_word  (w_word),
        .o_valid (w_we)
    );

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state  <= LEN_HI;
            r_count  <= '0;
            r_len    <= '0;
            r_len_hi <= '0;
            r_acc    <= '0;
            r_waddr  <= '0;
        end else begin
            if (w_lo_en) begin
                r_waddr <= r_count[ADDR_W-1:0];
                r_count <= w_count_nxt;
            end
            if (w_accept && (r_state != CSUM)) r_acc <= r_acc ^ bus.iDATA;

            case (r_state)
                LEN_HI: if (w_accept) begin
                    r_len_hi <= bus.iDATA;
                    r_state  <= LEN_LO;
                end
                LEN_LO: if (w_accept) begin
                    r_len <= w_len_full[ADDR_W:0];
                    if (w_len_full > DEPTH16)   r_state <= ERR;
                    else if (w_len_full == '0)  r_state <= CSUM;
                    else                        r_state <= DATA_HI;
                end
                DATA_HI: if (w_accept) r_state <= DATA_LO;
                DATA_LO: if (w_accept) r_state <= w_last ? CSUM : DATA_HI;
                CSUM: if (w_accept) r_state <= (bus.iDATA == r_acc) ? DONE : ERR;
                DONE, ERR: if (bus.iRELOAD) begin
                    r_state <= LEN_HI;
                    r_count <= '0;
                    r_acc   <= '0;
                end
                default: r_state <= LEN_HI;
            endcase
        end
    end

    assign bus.oREADY = w_ready;
    assign bus.oWE    = w_we;
    assign bus.oWADDR = r_waddr;
    assign bus.oWDATA = w_word;
    assign bus.oRUN   = (r_state == DONE);
    assign bus.oERR   = (r_state == ERR);
    assign bus.oCOUNT = r_count;
    assign bus.oSTATE = r_state;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad checksum, oversize length, empty
// frame, full-depth frame and asynchronous reset mid-frame.
module tb_imem_loader;
    import bpf_pkg::*;

    logic clk;
    logic iRST;
    int   n_chk;
    int   n_bad;
    int   n_wr;
    int   b_addr;
    logic [7:0]  b_acc;
    logic [23:0] exp_q[$];

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .DEPTH(256)) dut (
        .iCLK (clk),
        .iRST (iRST),
        .bus  (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // drivers
    task automatic send_byte(input logic [7:0] b);
        bus.iDATA  = b;
        bus.iVALID = 1'b1;
        b_acc      = b_acc ^ b;
        @(posedge clk);
        #1;
    endtask

    task automatic frame_start(input logic [15:0] n);
        b_acc  = 8'h00;
        b_addr = 0;
        n_wr   = 0;
        send_byte(n[15:8]);
        send_byte(n[7:0]);
    endtask

    task automatic send_word(input logic [15:0] w);
        logic [7:0] a;
        a = b_addr[7:0];
        exp_q.push_back({a, w});
        b_addr++;
        send_byte(w[15:8]);
        send_byte(w[7:0]);
    endtask

    task automatic idle();
        bus.iVALID = 1'b0;
        bus.iDATA  = 8'h00;
    endtask

    task automatic reload();
        bus.iRELOAD = 1'b1;
        @(posedge clk);
        #1;
        bus.iRELOAD = 1'b0;
    endtask

    // scoreboard: every write pulse is matched against the expected queue
    always @(negedge clk) begin
        if (bus.oWE === 1'b1) begin
            n_wr++;
            if (exp_q.size() > 0) chk("write", {bus.oWADDR, bus.oWDATA}, exp_q.pop_front());
        end
    end

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_nwr"}, n_wr, n);
        chk({tag, "_qleft"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] w_hi;
        logic [7:0] w_lo;
        logic [7:0] cs;
        n_chk = 0; n_bad = 0; n_wr = 0; b_acc = 8'h00; b_addr = 0;
        bus.iDATA = 8'h00; bus.iVALID = 1'b0; bus.iRELOAD = 1'b0;
        iRST = 1'b1;
        #2 iRST = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.oREADY, 1);
        chk("rst_we",    bus.oWE,    0);
        chk("rst_waddr", bus.oWADDR, 0);
        chk("rst_wdata", bus.oWDATA, 0);
        chk("rst_run",   bus.oRUN,   0);
        chk("rst_err",   bus.oERR,   0);
        chk("rst_count", bus.oCOUNT, 0);
        chk("rst_state", bus.oSTATE, LEN_HI);
        @(negedge clk);
        iRST = 1'b1;

        // good frame 00 02 12 34 AB CD / 42
        frame_start(16'd2);
        send_word(16'h1234);
        send_word(16'hABCD);
        chk("t1_count", bus.oCOUNT, 2);
        send_byte(8'h42);
        idle();
        chk("t1_run",   bus.oRUN,   1);
        chk("t1_ready", bus.oREADY, 0);
        chk("t1_err",   bus.oERR,   0);
        check_writes("t1", 2);
        reload();
        chk("t1_rl_run",   bus.oRUN,   0);
        chk("t1_rl_count", bus.oCOUNT, 0);

        // same frame, bad checksum 43
        frame_start(16'd2);
        send_word(16'h1234);
        send_word(16'hABCD);
        send_byte(8'h43);
        idle();
        chk("t2_err",   bus.oERR,   1);
        chk("t2_run",   bus.oRUN,   0);
        chk("t2_count", bus.oCOUNT, 2);
        check_writes("t2", 2);
        chk("t2_hold_addr", bus.oWADDR, 1);
        chk("t2_hold_data", bus.oWDATA, 16'hABCD);
        reload();
        chk("t2_rl_err",   bus.oERR,   0);
        chk("t2_rl_state", bus.oSTATE, LEN_HI);
        chk("t2_rl_count", bus.oCOUNT, 0);
        chk("t2_rl_ready", bus.oREADY, 1);

        // oversize length 01 01, then bytes offered while not ready
        frame_start(16'h0101);
        chk("t3_err", bus.oERR, 1);
        send_byte(8'h55);
        send_byte(8'h66);
        idle();
        chk("t3_state", bus.oSTATE, ERR);
        chk("t3_count", bus.oCOUNT, 0);
        check_writes("t3", 0);
        reload();

        // empty frame 00 00 / 00, with a stray reload mid-header
        b_acc = 8'h00; n_wr = 0;
        send_byte(8'h00);
        idle();
        reload();
        chk("t4_reload_ignored", bus.oSTATE, LEN_LO);
        send_byte(8'h00);
        chk("t4_state_csum", bus.oSTATE, CSUM);
        send_byte(8'h00);
        idle();
        chk("t4_run",   bus.oRUN,   1);
        chk("t4_count", bus.oCOUNT, 0);
        check_writes("t4", 0);
        reload();

        // full-depth frame, one byte every cycle
        frame_start(16'd256);
        for (int i = 0; i < 256; i++) begin
            w_lo = 8'(i);
            w_hi = w_lo ^ 8'h3C;
            send_word({w_hi, w_lo});
        end
        chk("t5_count", bus.oCOUNT, 256);
        cs = b_acc;
        send_byte(cs);
        idle();
        chk("t5_run", bus.oRUN, 1);
        chk("t5_err", bus.oERR, 0);
        check_writes("t5", 256);
        reload();

        // full frame cut by reset after word 10
        frame_start(16'd256);
        for (int i = 0; i < 10; i++) begin
            w_lo = 8'(i);
            w_hi = w_lo ^ 8'h3C;
            send_word({w_hi, w_lo});
        end
        idle();
        @(posedge clk);
        #1;
        chk("t6_pre_count", bus.oCOUNT, 10);
        check_writes("t6_pre", 10);
        iRST = 1'b0;
        #1;
        chk("t6_rst_state", bus.oSTATE, LEN_HI);
        chk("t6_rst_ready", bus.oREADY, 1);
        chk("t6_rst_count", bus.oCOUNT, 0);
        chk("t6_rst_waddr", bus.oWADDR, 0);
        chk("t6_rst_wdata", bus.oWDATA, 0);
        chk("t6_rst_we",    bus.oWE,    0);
        @(negedge clk);
        iRST = 1'b1;
        frame_start(16'd1);
        send_word(16'hBEEF);
        send_byte(8'h50);
        idle();
        chk("t6_run",   bus.oRUN,   1);
        chk("t6_count", bus.oCOUNT, 1);
        check_writes("t6", 1);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the fetch stage reads by PC.
- Accepts a byte-serial program frame from the host/debug link and assembles 16-bit instruction words.
- Writes the words into the instruction RAM write port at consecutive addresses from 0.
- Verifies a trailing XOR checksum, then releases the CPU to run (oRUN). The CPU is held off while loading.

Parameters:
- ADDR_W, 8, width of the instruction address; matches the 8-bit PC.
- DEPTH, 256, maximum number of instruction words accepted; must be ≤ 2^ADDR_W.

Ports:
- iCLK  in  1  clock; all state changes on posedge.
- iRST  in  1  asynchronous reset, active-low.
- iDATA  in  8  frame byte.
- iVALID  in  1  iDATA valid.
- oREADY  out  1  loader can accept a byte.
- iRELOAD  in  1  one-cycle pulse; restarts the loader from DONE or ERR.
- oWE  out  1  instruction RAM write enable.
- oWADDR  out  ADDR_W  write address.
- oWDATA  out  16  instruction word to write.
- oRUN  out  1  program loaded and checksum good; CPU may fetch.
- oERR  out  1  frame rejected.
- oCOUNT  out  ADDR_W+1  number of words written in the current frame.

Behaviour:
- Reset: iRST low forces the following asynchronously:
  - state = LEN_HI
  - oREADY = 1
  - oWE = 0, oWADDR = 0, oWDATA = 0
  - oRUN = 0, oERR = 0, oCOUNT = 0
  - checksum accumulator = 0
  - Reset mid-frame discards the partial frame; words already written stay in RAM.
- Byte transfer: a byte is accepted on a posedge where iVALID && oREADY. oREADY is 1 in states LEN_HI, LEN_LO, DATA_HI, DATA_LO and CSUM, and 0 in DONE and ERR.
- Frame format (all big-endian):
  - LEN_HI, LEN_LO: word count N.
  - N × (instruction high byte, instruction low byte).
  - CSUM: one byte equal to the XOR of all preceding frame bytes.
- State machine, one transition per accepted byte:
  - LEN_HI → LEN_LO.
  - LEN_LO:
    - N > DEPTH → ERR.
    - N == 0 → CSUM.
    - otherwise → DATA_HI.
  - DATA_HI → DATA_LO; the high byte is latched.
  - DATA_LO:
    - Registers oWDATA = {hi, lo}, oWADDR = oCOUNT[ADDR_W-1:0] and oWE = 1 on the next cycle (one-cycle pulse).
    - oCOUNT increments in the same cycle that oWE is 1.
    - Goes to CSUM if this was word N, else to DATA_HI.
  - CSUM:
    - Byte equals accumulator → DONE, oRUN = 1.
    - Otherwise → ERR, oERR = 1.
  - DONE: holds oRUN = 1. iRELOAD → LEN_HI; oRUN drops and oCOUNT and the accumulator clear on the same edge.
  - ERR: holds oERR = 1. iRELOAD → LEN_HI; oERR and oCOUNT clear.
- Timing:
  - Write latency: 1 cycle from acceptance of the low byte to oWE = 1.
  - The loader may accept the next high byte in the same cycle oWE is 1; back-to-back bytes every cycle are supported, with no bubbles.
- Accumulator: XOR of every accepted byte in LEN_HI through DATA_LO; it is not updated by the CSUM byte.
- Boundaries:
  - N == DEPTH is legal and writes addresses 0..DEPTH-1; oCOUNT reaches DEPTH without wrapping, hence the ADDR_W+1 width.
  - iRELOAD in a state other than DONE or ERR is ignored.
  - iVALID while oREADY = 0 is ignored: no byte is consumed and there is no error.
- oWADDR and oWDATA hold their last value when oWE = 0.

Decomposition:
- Shared package `bpf_pkg` holds:
  - state encoding constants LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, DONE, ERR (3 bits);
  - INSN_W = 16;
  - the default DEPTH.
- One natural sub-module: `byte_to_word`, which pairs hi/lo bytes into a 16-bit word with a registered valid pulse.
- FSM, counter and checksum stay in `imem_loader`.

Test Plan:
- Reset → all outputs at their reset values and oREADY = 1.
- Frame 00 02 12 34 AB CD with checksum 00^02^12^34^AB^CD = 0x42:
  - oWE pulses with addr 0 / data 0x1234, then addr 1 / data 0xABCD;
  - oCOUNT = 2, then oRUN = 1 and oREADY = 0.
- Same frame with checksum byte 0x43:
  - both writes still occur;
  - then oERR = 1 and oRUN = 0.
  - iRELOAD → oERR = 0, state LEN_HI, oCOUNT = 0.
- Length header 01 01 (257 > DEPTH) → oERR = 1 right after the second byte, with no oWE.
- Length 00 00 followed by checksum 00 → oRUN = 1 with no writes.
- Full frame of N = 256 with iVALID held high every cycle:
  - 256 writes at addresses 0..255, one every 2 cycles;
  - oCOUNT = 256, then oRUN = 1.
- Same full N = 256 frame with iRST pulsed low after word 10 → outputs reset immediately; a fresh frame then loads from address 0.
